// File: rtl/lcd_timing_gen_pkg.sv
// Shared types for the LCD timing generator: register map, per-axis timing and full config.
package lcd_timing_pkg;

    // Timing fields are held at a fixed width; writes are masked to the axis width.
    localparam int AXIS_W = 16;
    localparam int TOT_W  = AXIS_W + 2;

    typedef enum logic [3:0] {
        ADDR_H_ACTIVE = 4'd0,
        ADDR_H_FP     = 4'd1,
        ADDR_H_SW     = 4'd2,
        ADDR_H_BP     = 4'd3,
        ADDR_V_ACTIVE = 4'd4,
        ADDR_V_FP     = 4'd5,
        ADDR_V_SW     = 4'd6,
        ADDR_V_BP     = 4'd7,
        ADDR_POL      = 4'd8,
        ADDR_LINE     = 4'd9,
        ADDR_COMMIT   = 4'd10
    } cfg_addr_e;

    typedef struct packed {
        logic [AXIS_W-1:0] active;
        logic [AXIS_W-1:0] fp;
        logic [AXIS_W-1:0] sw;
        logic [AXIS_W-1:0] bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
        logic         hs_pol;
        logic         vs_pol;
    } timing_cfg_t;

    function automatic logic [TOT_W-1:0] axis_total(input axis_timing_t a);
        return TOT_W'(a.active) + TOT_W'(a.fp) + TOT_W'(a.sw) + TOT_W'(a.bp);
    endfunction

    function automatic axis_timing_t mk_axis(input int act, input int fp, input int sw, input int bp);
        axis_timing_t a;
        a.active = AXIS_W'(act);
        a.fp     = AXIS_W'(fp);
        a.sw     = AXIS_W'(sw);
        a.bp     = AXIS_W'(bp);
        return a;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_axis.sv
// One timing axis: wrapping counter plus active-region and sync-region decode of the current count.
import lcd_timing_pkg::*;

module lcd_timing_axis #(
    parameter int W = 11
) (
    input  logic             CLK_PXCLK,
    input  logic             RESET,
    input  logic             en,
    input  axis_timing_t     cfg,
    output logic [W-1:0]     cnt,
    output logic [TOT_W-1:0] total,
    output logic             last,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);

    logic [TOT_W-1:0] cnt_w;
    logic [TOT_W-1:0] sync_start;
    logic [TOT_W-1:0] sync_end;

    always_comb begin
        cnt_w      = TOT_W'(cnt);
        total      = axis_total(cfg);
        sync_start = TOT_W'(cfg.active) + TOT_W'(cfg.fp);
        sync_end   = sync_start + TOT_W'(cfg.sw);
        // >= keeps the counter bounded even if it were ever past the end
        last       = (cnt_w >= total - TOT_W'(1));
        wrap       = en & last;
        in_active  = (cnt_w < TOT_W'(cfg.active));
        in_sync    = (cnt_w >= sync_start) && (cnt_w < sync_end);
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD/RGB timing generator: staged, frame-atomic config; registered sync/DE/coords and frame events.
import lcd_timing_pkg::*;

module lcd_timing_gen #(
    parameter int X_BITS        = 11,
    parameter int Y_BITS        = 11,
    parameter int FRAME_BITS    = 16,
    parameter int PREFETCH_LEAD = 16,
    parameter int DEF_H_ACTIVE  = 800,
    parameter int DEF_H_FP      = 12,
    parameter int DEF_H_SW      = 29,
    parameter int DEF_H_BP      = 13,
    parameter int DEF_V_ACTIVE  = 480,
    parameter int DEF_V_FP      = 8,
    parameter int DEF_V_SW      = 9,
    parameter int DEF_V_BP      = 23,
    parameter bit DEF_HS_POL    = 1'b0,
    parameter bit DEF_VS_POL    = 1'b0
) (
    input  logic                  CLK_PXCLK,
    input  logic                  RESET,
    input  logic                  CFG_WE,
    input  logic [3:0]            CFG_ADDR,
    input  logic [15:0]           CFG_WDATA,
    output logic                  CFG_PENDING,
    output logic                  CFG_ERR,
    output logic                  HSYNC,
    output logic                  VSYNC,
    output logic                  DE,
    output logic [X_BITS-1:0]     X,
    output logic [Y_BITS-1:0]     Y,
    output logic                  BEFORE_FRAME,
    output logic                  AFTER_FRAME,
    output logic                  LINE_EVT,
    output logic [FRAME_BITS-1:0] FRAME_CNT
);

    localparam timing_cfg_t DEF_CFG = '{
        h:      mk_axis(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SW, DEF_H_BP),
        v:      mk_axis(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SW, DEF_V_BP),
        hs_pol: DEF_HS_POL,
        vs_pol: DEF_VS_POL
    };
    localparam logic [AXIS_W-1:0] X_MASK = AXIS_W'((1 << X_BITS) - 1);
    localparam logic [AXIS_W-1:0] Y_MASK = AXIS_W'((1 << Y_BITS) - 1);
    localparam logic [TOT_W-1:0]  X_LIM  = TOT_W'(1 << X_BITS);
    localparam logic [TOT_W-1:0]  Y_LIM  = TOT_W'(1 << Y_BITS);
    localparam logic [TOT_W-1:0]  LEAD   = TOT_W'(PREFETCH_LEAD);

    timing_cfg_t       act;
    timing_cfg_t       stg;
    logic [Y_BITS-1:0] line_match;

    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [TOT_W-1:0]  h_total, v_total;
    logic              h_last, h_wrap, h_act, h_sync;
    logic              v_last, v_wrap, v_act, v_sync;

    lcd_timing_axis #(.W(X_BITS)) u_h (
        .CLK_PXCLK (CLK_PXCLK),
        .RESET     (RESET),
        .en        (1'b1),
        .cfg       (act.h),
        .cnt       (x),
        .total     (h_total),
        .last      (h_last),
        .wrap      (h_wrap),
        .in_active (h_act),
        .in_sync   (h_sync)
    );

    lcd_timing_axis #(.W(Y_BITS)) u_v (
        .CLK_PXCLK (CLK_PXCLK),
        .RESET     (RESET),
        .en        (h_wrap),
        .cfg       (act.v),
        .cnt       (y),
        .total     (v_total),
        .last      (v_last),
        .wrap      (v_wrap),
        .in_active (v_act),
        .in_sync   (v_sync)
    );

    // v only advances on h wrap, so its wrap is exactly the frame boundary
    logic frame_bnd;
    logic commit_now;
    logic stg_ok;
    logic [TOT_W-1:0] stg_htot, stg_vtot;

    always_comb begin
        frame_bnd  = v_wrap;
        commit_now = CFG_WE && (CFG_ADDR == ADDR_COMMIT);
        stg_htot   = axis_total(stg.h);
        stg_vtot   = axis_total(stg.v);
        stg_ok     = (stg.h.active != '0) && (stg.v.active != '0) &&
                     (stg.h.sw != '0) && (stg.v.sw != '0) &&
                     (stg_htot <= X_LIM) && (stg_vtot <= Y_LIM) &&
                     (LEAD < stg_htot);
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET) begin
            act         <= DEF_CFG;
            stg         <= DEF_CFG;
            line_match  <= '0;
            CFG_PENDING <= 1'b0;
            CFG_ERR     <= 1'b0;
        end else begin
            if (CFG_WE) begin
                CFG_ERR <= 1'b0;
                case (CFG_ADDR)
                    ADDR_H_ACTIVE: stg.h.active <= CFG_WDATA & X_MASK;
                    ADDR_H_FP:     stg.h.fp     <= CFG_WDATA & X_MASK;
                    ADDR_H_SW:     stg.h.sw     <= CFG_WDATA & X_MASK;
                    ADDR_H_BP:     stg.h.bp     <= CFG_WDATA & X_MASK;
                    ADDR_V_ACTIVE: stg.v.active <= CFG_WDATA & Y_MASK;
                    ADDR_V_FP:     stg.v.fp     <= CFG_WDATA & Y_MASK;
                    ADDR_V_SW:     stg.v.sw     <= CFG_WDATA & Y_MASK;
                    ADDR_V_BP:     stg.v.bp     <= CFG_WDATA & Y_MASK;
                    ADDR_POL: begin
                        stg.hs_pol <= CFG_WDATA[0];
                        stg.vs_pol <= CFG_WDATA[1];
                    end
                    ADDR_LINE:     line_match   <= CFG_WDATA[Y_BITS-1:0];
                    default: ;
                endcase
            end
            // Apply is the last word on CFG_ERR this cycle, so a rejection is never masked
            if (frame_bnd && (CFG_PENDING || commit_now)) begin
                CFG_PENDING <= 1'b0;
                if (stg_ok)
                    act <= stg;
                else
                    CFG_ERR <= 1'b1;
            end else if (commit_now) begin
                CFG_PENDING <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET) begin
            X            <= '0;
            Y            <= '0;
            DE           <= 1'b0;
            HSYNC        <= ~DEF_HS_POL;
            VSYNC        <= ~DEF_VS_POL;
            BEFORE_FRAME <= 1'b0;
            AFTER_FRAME  <= 1'b0;
            LINE_EVT     <= 1'b0;
            FRAME_CNT    <= '0;
        end else begin
            X            <= x;
            Y            <= y;
            DE           <= h_act & v_act;
            HSYNC        <= h_sync ^ ~act.hs_pol;
            VSYNC        <= v_sync ^ ~act.vs_pol;
            BEFORE_FRAME <= v_last && (TOT_W'(x) == h_total - LEAD);
            AFTER_FRAME  <= (TOT_W'(x) == TOT_W'(act.h.active) - TOT_W'(1)) &&
                            (TOT_W'(y) == TOT_W'(act.v.active) - TOT_W'(1));
            LINE_EVT     <= (x == '0) && (y == line_match);
            if (frame_bnd)
                FRAME_CNT <= FRAME_CNT + FRAME_BITS'(1);
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen; reduced reset timing (53x21) keeps full-frame runs short.
module tb_lcd_timing_gen;

    localparam int HT = 53;
    localparam int VT = 21;
    localparam int SHT = 14;
    localparam int SVT = 8;

    logic        CLK_PXCLK = 1'b0;
    logic        RESET     = 1'b1;
    logic        CFG_WE    = 1'b0;
    logic [3:0]  CFG_ADDR  = '0;
    logic [15:0] CFG_WDATA = '0;
    logic        CFG_PENDING, CFG_ERR, HSYNC, VSYNC, DE;
    logic [10:0] X, Y;
    logic        BEFORE_FRAME, AFTER_FRAME, LINE_EVT;
    logic [15:0] FRAME_CNT;

    lcd_timing_gen #(
        .X_BITS(11), .Y_BITS(11), .FRAME_BITS(16), .PREFETCH_LEAD(4),
        .DEF_H_ACTIVE(40), .DEF_H_FP(4), .DEF_H_SW(6), .DEF_H_BP(3),
        .DEF_V_ACTIVE(12), .DEF_V_FP(2), .DEF_V_SW(3), .DEF_V_BP(4),
        .DEF_HS_POL(1'b0), .DEF_VS_POL(1'b0)
    ) dut (
        .CLK_PXCLK(CLK_PXCLK), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_WDATA(CFG_WDATA), .CFG_PENDING(CFG_PENDING), .CFG_ERR(CFG_ERR),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .X(X), .Y(Y),
        .BEFORE_FRAME(BEFORE_FRAME), .AFTER_FRAME(AFTER_FRAME), .LINE_EVT(LINE_EVT),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK_PXCLK = ~CLK_PXCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_PXCLK);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        CFG_WE    = 1'b1;
        CFG_ADDR  = 4'(addr);
        CFG_WDATA = 16'(data);
        tick();
        CFG_WE    = 1'b0;
    endtask

    int m_de, m_hs, m_hs_x, m_vs, m_vs_y;
    int m_bf, m_bf_x, m_bf_y, m_af, m_af_x, m_af_y, m_af_de, m_le, m_le_x, m_le_y;

    task automatic measure(input int n, input logic hpol, input logic vpol);
        m_de = 0; m_hs = 0; m_hs_x = -1; m_vs = 0; m_vs_y = -1;
        m_bf = 0; m_bf_x = -1; m_bf_y = -1; m_af = 0; m_af_x = -1; m_af_y = -1; m_af_de = -1;
        m_le = 0; m_le_x = -1; m_le_y = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (DE) m_de++;
            if (HSYNC == hpol) begin m_hs++; if (m_hs_x < 0) m_hs_x = int'(X); end
            if (VSYNC == vpol) begin m_vs++; if (m_vs_y < 0) m_vs_y = int'(Y); end
            if (BEFORE_FRAME) begin m_bf++; m_bf_x = int'(X); m_bf_y = int'(Y); end
            if (AFTER_FRAME) begin m_af++; m_af_x = int'(X); m_af_y = int'(Y); m_af_de = int'(DE); end
            if (LINE_EVT) begin m_le++; m_le_x = int'(X); m_le_y = int'(Y); end
        end
    endtask

    task automatic wait_pending_clear(input string tag);
        for (int i = 0; i < 400 && CFG_PENDING; i++) tick();
        chk(tag, int'(CFG_PENDING), 0);
    endtask

    initial begin
        bit found;

        // Reset state
        tick(); tick();
        chk("rst_x", int'(X), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_de", int'(DE), 0);
        chk("rst_hs", int'(HSYNC), 1);
        chk("rst_vs", int'(VSYNC), 1);
        chk("rst_pend", int'(CFG_PENDING), 0);
        chk("rst_err", int'(CFG_ERR), 0);
        chk("rst_fcnt", int'(FRAME_CNT), 0);
        chk("rst_pulses", int'({BEFORE_FRAME, AFTER_FRAME, LINE_EVT}), 0);

        // Two frames of reset timing
        RESET = 1'b0;
        measure(2 * HT * VT, 1'b0, 1'b0);
        chk("def_de", m_de, 2 * 40 * 12);
        chk("def_hs_cnt", m_hs, 2 * VT * 6);
        chk("def_hs_x", m_hs_x, 44);
        chk("def_vs_cnt", m_vs, 2 * 3 * HT);
        chk("def_vs_y", m_vs_y, 14);
        chk("def_fcnt", int'(FRAME_CNT), 2);
        chk("def_bf_cnt", m_bf, 2);
        chk("def_bf_x", m_bf_x, HT - 4);
        chk("def_bf_y", m_bf_y, VT - 1);
        chk("def_af_xy", m_af_x * 100 + m_af_y, 39 * 100 + 11);
        chk("def_le_y", m_le_y, 0);
        chk("def_end_xy", int'(X) * 100 + int'(Y), 52 * 100 + 20);

        // Small config committed mid-frame
        for (int i = 0; i < 20; i++) tick();
        wr(0, 8); wr(1, 2); wr(2, 3); wr(3, 1);
        wr(4, 4); wr(5, 1); wr(6, 2); wr(7, 1);
        wr(8, 3); wr(10, 0);
        chk("cmt_pend", int'(CFG_PENDING), 1);
        found = 0;
        for (int i = 0; i < 3 * HT * VT && !found; i++) begin
            tick();
            if (X == 11'd51 && Y == 11'd20) found = 1;
        end
        chk("cmt_reach_bnd", int'(found), 1);
        chk("cmt_pend_pre", int'(CFG_PENDING), 1);
        tick();
        chk("cmt_old_last_x", int'(X), 52);
        chk("cmt_pend_post", int'(CFG_PENDING), 0);
        measure(2 * SHT * SVT, 1'b1, 1'b1);
        chk("sm_de", m_de, 2 * 8 * 4);
        chk("sm_hs_cnt", m_hs, 2 * SVT * 3);
        chk("sm_hs_x", m_hs_x, 10);
        chk("sm_vs_cnt", m_vs, 2 * 2 * SHT);
        chk("sm_vs_y", m_vs_y, 5);
        chk("sm_bf_xy", m_bf_x * 100 + m_bf_y, 10 * 100 + 7);
        chk("sm_af_cnt", m_af, 2);
        chk("sm_af_xyde", m_af_x * 1000 + m_af_y * 10 + m_af_de, 7 * 1000 + 3 * 10 + 1);

        // BEFORE_FRAME leads DE at (0,0) by 4 cycles
        found = 0;
        for (int i = 0; i < 3 * SHT * SVT && !found; i++) begin
            tick();
            if (BEFORE_FRAME) found = 1;
        end
        chk("bf_seen", int'(found), 1);
        chk("bf_at", int'(X) * 100 + int'(Y), 10 * 100 + 7);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("bf_gap_de", int'(DE), 0);
        end
        tick();
        chk("bf_lead_pix", int'(X) * 1000 + int'(Y) * 10 + int'(DE), 1);

        // LINE_MATCH
        wr(9, 2);
        measure(SHT * SVT, 1'b1, 1'b1);
        chk("le2_cnt", m_le, 1);
        chk("le2_xy", m_le_x * 100 + m_le_y, 2);
        wr(9, 9);
        measure(2 * SHT * SVT, 1'b1, 1'b1);
        chk("le9_cnt", m_le, 0);

        // Rejected applies: zero sync width, then H total over 2^X_BITS
        wr(2, 0); wr(10, 0);
        wait_pending_clear("rej_sw_pend");
        chk("rej_sw_err", int'(CFG_ERR), 1);
        measure(SHT * SVT, 1'b1, 1'b1);
        chk("rej_sw_de", m_de, 32);
        chk("rej_sw_hs", m_hs, 24);
        wr(2, 3);
        chk("rej_sw_err_clr", int'(CFG_ERR), 0);
        wr(0, 2047); wr(10, 0);
        wait_pending_clear("rej_ovf_pend");
        chk("rej_ovf_err", int'(CFG_ERR), 1);
        measure(SHT * SVT, 1'b1, 1'b1);
        chk("rej_ovf_de", m_de, 32);
        wr(0, 8);
        chk("rej_ovf_err_clr", int'(CFG_ERR), 0);

        // RESET mid-frame discards a pending commit
        wr(0, 6); wr(10, 0);
        chk("mr_pend", int'(CFG_PENDING), 1);
        found = 0;
        for (int i = 0; i < 3 * SHT * SVT && !found; i++) begin
            tick();
            if (Y == 11'd2) found = 1;
        end
        chk("mr_y2", int'(found), 1);
        RESET = 1'b1;
        tick();
        chk("mr_xy", int'(X) * 100 + int'(Y), 0);
        chk("mr_de", int'(DE), 0);
        chk("mr_sync", int'({HSYNC, VSYNC}), 3);
        chk("mr_pend_clr", int'(CFG_PENDING), 0);
        chk("mr_fcnt", int'(FRAME_CNT), 0);
        RESET = 1'b0;
        measure(HT * VT, 1'b0, 1'b0);
        chk("mr_def_de", m_de, 480);
        chk("mr_def_hs_x", m_hs_x, 44);
        chk("mr_def_fcnt", int'(FRAME_CNT), 1);
        chk("mr_def_pend", int'(CFG_PENDING), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
